rxll_frame_reader: RTL

Read-side frame engine for the receive LocalLink FIFO: it drains complete frames from a 36-bit first-word-fall-through FIFO in the rd_clk domain and replays them as a LocalLink source toward the AHCI command/DMA logic. A frame is started only once the FIFO reports a whole frame buffered. Frames are then streamed at one word per cycle under downstream backpressure. The block also checks framing, caps frame length and reports per-frame length and error status.

---
 rtl/rxll_frame_reader_if.sv | 27 ++
 rtl/rxll_frame_reader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rxll_frame_reader_if.sv
// FIFO read port and LocalLink source bundle for the receive frame reader.
// The master side is the frame reader; the slave side is the FIFO plus downstream sink.
interface rxll_frame_reader_if;
  logic [35:0] fifo_do;
  logic        fifo_empty;
  logic        fifo_eof_rdy;
  logic        fifo_rd_en;
  logic [31:0] ll_data;
  logic        ll_sof_n;
  logic        ll_eof_n;
  logic        ll_src_rdy_n;
  logic        ll_dst_rdy_n;

  modport master (
    input  fifo_do, fifo_empty, fifo_eof_rdy,
    output fifo_rd_en,
    output ll_data, ll_sof_n, ll_eof_n, ll_src_rdy_n,
    input  ll_dst_rdy_n
  );

  modport slave (
    output fifo_do, fifo_empty, fifo_eof_rdy,
    input  fifo_rd_en,
    input  ll_data, ll_sof_n, ll_eof_n, ll_src_rdy_n,
    output ll_dst_rdy_n
  );
endinterface

// File: rtl/rxll_frame_reader.sv
// Drains whole frames from a FWFT FIFO and replays them as a LocalLink source,
// checking framing, capping frame length and reporting length/error per frame.
module rxll_frame_reader #(
  parameter int C_MAX_WORDS = 2048,
  parameter int C_CNT_W     = 12
) (
  input  logic                   rd_clk,
  input  logic                   rst,
  rxll_frame_reader_if.master    bus,
  output logic                   frm_done,
  output logic [C_CNT_W-1:0]     frm_len,
  output logic                   frm_err,
  output logic                   busy
);
  typedef enum logic [2:0] {S_IDLE, S_XFER, S_LAST, S_DRAIN, S_DONE} state_t;

  localparam logic [C_CNT_W-1:0] MAX_CNT = C_CNT_W'(C_MAX_WORDS);

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                 err_q, err_d;
  logic                 drain_q, drain_d;
  logic                 first_q, first_d;
  logic                 ov_q, ov_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic [31:0]          data_q, data_d;
  logic                 frm_done_q, frm_done_d;
  logic [C_CNT_W-1:0]   frm_len_q, frm_len_d;
  logic                 frm_err_q, frm_err_d;
  logic                 pop;
  logic                 accept;
  logic                 w_sof, w_eof, w_err;
  logic                 fifo_unused;

  assign w_sof       = bus.fifo_do[32];
  assign w_eof       = bus.fifo_do[34];
  assign w_err       = bus.fifo_do[35];
  assign fifo_unused = bus.fifo_do[33];

  assign accept  = ov_q && !bus.ll_dst_rdy_n;
  assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + C_CNT_W'(1);

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    drain_d    = drain_q;
    first_d    = first_q;
    ov_d       = ov_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    data_d     = data_q;
    frm_len_d  = frm_len_q;
    frm_err_d  = frm_err_q;
    pop        = 1'b0;

    // An accepted word empties the output stage unless a pop below refills it.
    if (accept) begin
      ov_d  = 1'b0;
      sof_d = 1'b0;
      eof_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.fifo_eof_rdy && !bus.fifo_empty) begin
          cnt_d   = '0;
          drain_d = 1'b0;
          if (w_sof) begin
            err_d   = 1'b0;
            first_d = 1'b1;
            state_d = S_XFER;
          end else begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_XFER: begin
        pop = !bus.fifo_empty && (!ov_q || !bus.ll_dst_rdy_n);
        if (pop) begin
          ov_d    = 1'b1;
          data_d  = bus.fifo_do[31:0];
          sof_d   = first_q;
          eof_d   = w_eof;
          first_d = 1'b0;
          cnt_d   = cnt_inc;
          if (w_err || (w_sof && !first_q)) err_d = 1'b1;
          if (w_eof) begin
            state_d = S_LAST;
          end else if (cnt_inc == MAX_CNT) begin
            // Length cap hit: close the frame on this word, discard the rest.
            eof_d   = 1'b1;
            err_d   = 1'b1;
            drain_d = 1'b1;
            state_d = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (accept) state_d = drain_q ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        pop = !bus.fifo_empty;
        if (pop && w_eof) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status is captured on entry to DONE so it is valid alongside the pulse.
    frm_done_d = (state_d == S_DONE);
    if (frm_done_d) begin
      frm_len_d = cnt_d;
      frm_err_d = err_d;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      drain_q    <= 1'b0;
      first_q    <= 1'b0;
      ov_q       <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      data_q     <= '0;
      frm_done_q <= 1'b0;
      frm_len_q  <= '0;
      frm_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every flop sample the same pre-edge _d values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      drain_q    <= drain_d;
      first_q    <= first_d;
      ov_q       <= ov_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      data_q     <= data_d;
      frm_done_q <= frm_done_d;
      frm_len_q  <= frm_len_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign bus.fifo_rd_en   = pop;
  assign bus.ll_data      = data_q;
  assign bus.ll_sof_n     = !sof_q;
  assign bus.ll_eof_n     = !eof_q;
  assign bus.ll_src_rdy_n = !ov_q;

  assign frm_done = frm_done_q;
  assign frm_len  = frm_len_q;
  assign frm_err  = frm_err_q;
  assign busy     = (state_q != S_IDLE);
endmodule
